radix8_booth_digit_decoder: RTL and testbench

// - Serial inverse of the radix-8 Booth recoder. Accepts one recoded digit per handshake, LSD first,
//   as flags s/d/t/q (magnitude 1/2/3/4) plus n (negate), and rebuilds the signed N-bit operand.
// - Sits on the multiplier side-channel as a round-trip checker and debug tap for recoder output.

---
 rtl/radix8_booth_digit_decoder.sv | 107 ++++++++++
 tb/tb_radix8_booth_digit_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/radix8_booth_digit_decoder.sv
// radix8_booth_digit_decoder: serial inverse of a radix-8 Booth recoder
//
// Accepts one recoded digit per in_valid/in_ready handshake, least significant
// digit first, and rebuilds the signed DATA_WIDTH-bit operand.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   digit flags valid
//   in_ready   decoder can accept a digit (low while a result is held)
//   s,d,t,q    magnitude select 1/2/3/4, priority q>t>d>s, all zero = 0
//   n          negate digit
//   out_valid  reconstructed operand valid
//   out_ready  consumer accepts the result
//   x_out      reconstructed operand, two's complement
//   ovf        full-width sum not representable in DATA_WIDTH signed
//   err        more than one magnitude flag seen in this operand
//
// Optional feature macro: RADIX8_CODE_CHECK_EN (illegal-code check drives err;
// without it err is tied low).
module radix8_booth_digit_decoder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  s,
    input  logic                  d,
    input  logic                  t,
    input  logic                  q,
    input  logic                  n,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] x_out,
    output logic                  ovf,
    output logic                  err
);
    localparam int NUM_DIGITS = (DATA_WIDTH + 2) / 3;
    localparam int ACC_W = 3 * NUM_DIGITS + 1;
    localparam int IDX_W = $clog2(NUM_DIGITS + 1);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum;
    logic [DATA_WIDTH-1:0]   x_q, x_d;
    logic                    ovf_q, ovf_d, out_valid_q, out_valid_d, in_ready_q, in_ready_d;
    logic [2:0]              m;
    logic signed [3:0]       v;
    logic                    accept, last, out_fire;
    // bits that must all equal the sign bit for the sum to fit DATA_WIDTH
    logic [ACC_W-DATA_WIDTH:0] top;
    assign accept   = in_valid && in_ready_q;
    assign last     = idx_q == IDX_W'(NUM_DIGITS - 1);
    assign out_fire = out_valid_q && out_ready;
    always_comb begin
        m   = q ? 3'd4 : t ? 3'd3 : d ? 3'd2 : s ? 3'd1 : 3'd0;
        v   = n ? -$signed({1'b0, m}) : $signed({1'b0, m});
        sum = acc_q + (ACC_W'(v) <<< (3 * idx_q));
        top = sum[ACC_W-1:DATA_WIDTH-1];
        state_d     = accept ? (last ? HOLD : ACCUM) : out_fire ? IDLE : state_q;
        idx_d       = accept ? (last ? '0 : idx_q + IDX_W'(1)) : idx_q;
        acc_d       = accept ? (last ? '0 : sum) : acc_q;
        x_d         = accept && last ? sum[DATA_WIDTH-1:0] : x_q;
        ovf_d       = accept && last ? !(&top || ~|top) : ovf_q;
        out_valid_d = accept && last ? 1'b1 : out_fire ? 1'b0 : out_valid_q;
        in_ready_d  = state_d != HOLD;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end
`ifdef RADIX8_CODE_CHECK_EN
    logic err_q, err_d, multi;
    // sticky per operand; the first digit of a new operand restarts it
    always_comb begin
        multi = (s & d) | (s & t) | (s & q) | (d & t) | (d & q) | (t & q);
        err_d = accept ? ((idx_q == '0 ? 1'b0 : err_q) | multi) : err_q;
    end
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x_out     = x_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_radix8_booth_digit_decoder.sv
// tb_radix8_booth_digit_decoder: directed vector bench for the radix-8 Booth digit decoder
module tb_radix8_booth_digit_decoder;
    logic clk = 0, rst = 1, in_valid = 0, in_ready, s = 0, d = 0, t = 0, q = 0, n = 0;
    logic out_valid, out_ready = 0, ovf, err;
    logic [7:0] x_out;
    int n_cmp = 0, n_bad = 0;
    // digit flags packed as {n,q,t,d,s}
    localparam logic [4:0] Z = 5'b00000, NZ = 5'b10000;
    localparam logic [4:0] P1 = 5'b00001, M1 = 5'b10001, P2 = 5'b00010, M2 = 5'b10010;
    localparam logic [4:0] P3 = 5'b00100, P4 = 5'b01000, M4 = 5'b11000, SD = 5'b00011;
`ifdef RADIX8_CODE_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif
    typedef struct {
        string      name;
        logic [4:0] d0, d1, d2;
        logic [7:0] x;
        logic       ov;
    } vec_t;
    vec_t vecs [10];

    radix8_booth_digit_decoder #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .d(d), .t(t), .q(q), .n(n),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [4:0] f);
        int k = 0;
        @(negedge clk);
        {n, q, t, d, s} = f;
        in_valid = 1;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        {n, q, t, d, s} = Z;
    endtask

    task automatic handshake(input string nm);
        @(negedge clk);
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        chk({nm, "_valid_drop"}, {31'd0, out_valid}, 0);
        chk({nm, "_ready_rise"}, {31'd0, in_ready}, 1);
    endtask

    task automatic run_op(input string nm, input logic [4:0] d0, input logic [4:0] d1,
                          input logic [4:0] d2, input logic [7:0] x, input logic ov,
                          input logic er, input int gap);
        send(d0);
        repeat (gap) @(negedge clk);
        send(d1);
        chk({nm, "_no_early_valid"}, {31'd0, out_valid}, 0);
        repeat (gap) @(negedge clk);
        send(d2);
        chk({nm, "_valid"}, {31'd0, out_valid}, 1);
        chk({nm, "_x"}, {24'd0, x_out}, {24'd0, x});
        chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, ov});
        chk({nm, "_err"}, {31'd0, err}, {31'd0, er});
        handshake(nm);
    endtask

    initial begin
        vecs[0] = '{"m1_p1_0",   M1, P1, Z,  8'h07, 1'b0};
        vecs[1] = '{"p1_m1_0",   P1, M1, Z,  8'hF9, 1'b0};
        vecs[2] = '{"min_neg",   Z,  Z,  M2, 8'h80, 1'b0};
        vecs[3] = '{"p256_ovf",  Z,  Z,  P4, 8'h00, 1'b1};
        vecs[4] = '{"p3",        P3, Z,  Z,  8'h03, 1'b0};
        vecs[5] = '{"m292_ovf",  M4, M4, M4, 8'hDC, 1'b1};
        vecs[6] = '{"p91",       P3, P3, P1, 8'h5B, 1'b0};
        vecs[7] = '{"max_pos",   M1, Z,  P2, 8'h7F, 1'b0};
        vecs[8] = '{"p128_ovf",  Z,  Z,  P2, 8'h80, 1'b1};
        vecs[9] = '{"neg_zero",  NZ, NZ, NZ, 8'h00, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_x_out", {24'd0, x_out}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        chk("rst_err", {31'd0, err}, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 1);

        // idle with out_ready high must not disturb anything
        out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_out_ready_ignored", {31'd0, out_valid}, 0);
        out_ready = 0;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].name, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].x, vecs[i].ov, 1'b0, 0);

        // in_valid gaps between digits of one operand
        run_op("gaps", M1, P1, Z, 8'h07, 1'b0, 1'b0, 3);

        // result held for 5 cycles while a digit is offered; it must not be taken
        send(P1);
        send(P1);
        send(P1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            {n, q, t, d, s} = P4;
            in_valid = 1;
            @(posedge clk);
            #1;
            chk("hold_in_ready", {31'd0, in_ready}, 0);
            chk("hold_valid", {31'd0, out_valid}, 1);
            chk("hold_x", {24'd0, x_out}, 32'h49);
        end
        @(negedge clk);
        in_valid = 0;
        {n, q, t, d, s} = Z;
        handshake("hold");
        run_op("after_hold", P3, Z, Z, 8'h03, 1'b0, 1'b0, 0);

        // reset mid-operand discards partial sum
        send(P4);
        send(P4);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 0);
        chk("mid_rst_valid", {31'd0, out_valid}, 0);
        @(negedge clk);
        rst = 0;
        run_op("after_mid_rst", P3, Z, Z, 8'h03, 1'b0, 1'b0, 0);

        // reset while a result is held
        send(Z);
        send(Z);
        send(P4);
        chk("held_ovf_before_rst", {31'd0, ovf}, 1);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        chk("held_rst_valid", {31'd0, out_valid}, 0);
        chk("held_rst_x", {24'd0, x_out}, 0);
        chk("held_rst_ovf", {31'd0, ovf}, 0);
        @(negedge clk);
        rst = 0;

        // multi-flag digit decodes by priority; err only with the check enabled
        run_op("code_sd", SD, Z, Z, 8'h02, 1'b0, EXP_ERR, 0);
        chk("err_sticky_idle", {31'd0, err}, {31'd0, EXP_ERR});
        run_op("code_clean", P1, Z, Z, 8'h01, 1'b0, 1'b0, 0);
        run_op("code_late", Z, Z, SD, 8'h80, 1'b1, EXP_ERR, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
